// File: rtl/board_pkg.sv
// Shared definitions for the 2048 board updater.
// Cell packing: 16 cells of 4-bit log2 exponents, row-major, cell (0,0) in bits [63:60].
package board_pkg;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    localparam logic [3:0] TILE_EMPTY = 4'd0;
    localparam logic [3:0] TILE_WIN   = 4'd11;
    localparam logic [3:0] TILE_MAX   = 4'd15;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE0,
        S_LINE1,
        S_LINE2,
        S_LINE3,
        S_CHECK,
        S_SPAWN,
        S_DONE
    } state_t;

    // Top bit index of cell (r,c): 63 - 16r - 4c.
    function automatic logic [5:0] cell_msb(input logic [1:0] r, input logic [1:0] c);
        return 6'd63 - {r, 4'b0000} - {2'b00, c, 2'b00};
    endfunction

endpackage

// File: rtl/board_update_line_merge.sv
// Combinational 2048 line slide + merge.
// Ports:
//   line_in  : four 4-bit cells, element 0 is the side tiles slide towards
//   line_out : compacted and merged result, same orientation
// Each tile merges at most once; merged value saturates at TILE_MAX.
module line_merge
    import board_pkg::*;
(
    input  logic [3:0][3:0] line_in,
    output logic [3:0][3:0] line_out
);

    // Extra empty slot so cmp[i+1] is always in range while scanning pairs.
    logic [3:0] cmp [5];
    logic [2:0] wr;
    logic       skip;

    always_comb begin
        for (int i = 0; i < 5; i++) cmp[i] = TILE_EMPTY;
        line_out = '0;
        wr       = 3'd0;
        skip     = 1'b0;

        for (int i = 0; i < 4; i++) begin
            if (line_in[i] != TILE_EMPTY) begin
                cmp[wr] = line_in[i];
                wr      = wr + 3'd1;
            end
        end

        wr = 3'd0;
        for (int i = 0; i < 4; i++) begin
            if (skip) begin
                skip = 1'b0;
            end else if (cmp[i] != TILE_EMPTY) begin
                if (cmp[i] == cmp[i+1]) begin
                    line_out[wr[1:0]] = (cmp[i] == TILE_MAX) ? TILE_MAX : cmp[i] + 4'd1;
                    skip              = 1'b1;
                end else begin
                    line_out[wr[1:0]] = cmp[i];
                end
                wr = wr + 3'd1;
            end
        end
    end

endmodule

// File: rtl/board_update.sv
// 2048 board register owner: applies moves, spawns tiles, flags win/lose.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   dir_valid/dir/dir_ready : move request handshake (dir 0=up 1=down 2=left 3=right)
//   load_en/load_board    : force-load of the board, overrides any move in flight
//   board                 : committed board for the display path
//   update_done/moved     : end-of-move pulse and whether the board changed
//   win/lose              : registered status derived from board
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | waiting for a move; dir_ready high
// S_LINEi | slide/merge line i of the work copy in place
// S_CHECK | compare work against board, pick spawn start index
// S_SPAWN | scan one cell per cycle for an empty cell, place new tile
// S_DONE  | board committed, update_done high for this cycle
module board_update
    import board_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter logic [63:0] INIT_BOARD = 64'h1000_0000_0000_0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        dir_valid,
    input  logic [1:0]  dir,
    output logic        dir_ready,
    input  logic        load_en,
    input  logic [63:0] load_board,
    output logic [63:0] board,
    output logic        update_done,
    output logic        moved,
    output logic        win,
    output logic        lose
);

    state_t          state;
    logic [63:0]     work;
    logic [1:0]      dir_q;
    logic [15:0]     lfsr;
    logic [3:0]      scan_idx;

    logic [1:0]      line_idx;
    logic [5:0]      pos_msb [4];
    logic [3:0][3:0] ln_in;
    logic [3:0][3:0] ln_out;

    logic [5:0]      scan_msb;
    logic            scan_empty;
    logic [63:0]     work_spawned;
    logic            win_c;
    logic            lose_c;

    function automatic logic [3:0] cell_at(input logic [63:0] b, input logic [1:0] r,
                                           input logic [1:0] c);
        return b[cell_msb(r, c) -: 4];
    endfunction

    always_comb begin
        case (state)
            S_LINE1: line_idx = 2'd1;
            S_LINE2: line_idx = 2'd2;
            S_LINE3: line_idx = 2'd3;
            default: line_idx = 2'd0;
        endcase
    end

    // Position 0 of each extracted line is the edge tiles slide towards.
    always_comb begin
        for (int p = 0; p < 4; p++) begin
            case (dir_q)
                DIR_LEFT:  pos_msb[p] = cell_msb(line_idx, 2'(p));
                DIR_RIGHT: pos_msb[p] = cell_msb(line_idx, 2'd3 - 2'(p));
                DIR_UP:    pos_msb[p] = cell_msb(2'(p), line_idx);
                default:   pos_msb[p] = cell_msb(2'd3 - 2'(p), line_idx);
            endcase
            ln_in[p] = work[pos_msb[p] -: 4];
        end
    end

    line_merge u_line_merge (
        .line_in  (ln_in),
        .line_out (ln_out)
    );

    always_comb begin
        scan_msb     = 6'd63 - {scan_idx, 2'b00};
        scan_empty   = (work[scan_msb -: 4] == TILE_EMPTY);
        work_spawned = work;
        work_spawned[scan_msb -: 4] = (lfsr[7:4] == 4'd0) ? 4'd2 : 4'd1;
    end

    always_comb begin
        win_c  = 1'b0;
        lose_c = 1'b1;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (cell_at(board, 2'(r), 2'(c)) == TILE_WIN)   win_c  = 1'b1;
                if (cell_at(board, 2'(r), 2'(c)) == TILE_EMPTY) lose_c = 1'b0;
                if (c < 3 && cell_at(board, 2'(r), 2'(c)) == cell_at(board, 2'(r), 2'(c + 1)))
                    lose_c = 1'b0;
                if (r < 3 && cell_at(board, 2'(r), 2'(c)) == cell_at(board, 2'(r + 1), 2'(c)))
                    lose_c = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            board       <= INIT_BOARD;
            work        <= '0;
            dir_q       <= DIR_UP;
            lfsr        <= LFSR_SEED;
            scan_idx    <= 4'd0;
            dir_ready   <= 1'b1;
            update_done <= 1'b0;
            moved       <= 1'b0;
            win         <= 1'b0;
            lose        <= 1'b0;
        end else begin
            lfsr        <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
            win         <= win_c;
            lose        <= lose_c;
            update_done <= 1'b0;

            if (load_en) begin
                board     <= load_board;
                state     <= S_IDLE;
                dir_ready <= 1'b1;
                moved     <= 1'b0;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (dir_valid) begin
                            work      <= board;
                            dir_q     <= dir;
                            state     <= S_LINE0;
                            dir_ready <= 1'b0;
                        end
                    end
                    S_LINE0, S_LINE1, S_LINE2, S_LINE3: begin
                        for (int p = 0; p < 4; p++) work[pos_msb[p] -: 4] <= ln_out[p];
                        case (state)
                            S_LINE0: state <= S_LINE1;
                            S_LINE1: state <= S_LINE2;
                            S_LINE2: state <= S_LINE3;
                            default: state <= S_CHECK;
                        endcase
                    end
                    S_CHECK: begin
                        if (work == board) begin
                            moved       <= 1'b0;
                            update_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            scan_idx <= lfsr[3:0];
                            state    <= S_SPAWN;
                        end
                    end
                    S_SPAWN: begin
                        // A changed board always has an empty cell, so this terminates.
                        if (scan_empty) begin
                            work        <= work_spawned;
                            board       <= work_spawned;
                            moved       <= 1'b1;
                            update_done <= 1'b1;
                            state       <= S_DONE;
                        end else begin
                            scan_idx <= scan_idx + 4'd1;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        dir_ready <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule
